// File: rtl/adc_trig_pkg.sv
// Shared constants, enums and the lane-extract helper for the ADC level trigger.
// The 128-bit stream word carries eight left-justified signed 12-bit samples.
package adc_trig_pkg;

  localparam int unsigned NLANES        = 8;
  localparam int unsigned LANE_BITS     = 16;
  localparam int unsigned SAMPLE_BITS   = 12;
  localparam int unsigned SAMPLE_LSB    = 4;
  localparam int unsigned DATA_BITS     = NLANES * LANE_BITS;
  localparam int unsigned LANE_IDX_BITS = 3;

  typedef enum logic [1:0] {
    MODE_RISE = 2'd0,
    MODE_FALL = 2'd1,
    MODE_BOTH = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  // Signed 12-bit sample of one lane; lane 0 is earliest in time.
  function automatic logic signed [SAMPLE_BITS-1:0] lane_sample(
    input logic [DATA_BITS-1:0] data,
    input int unsigned          lane
  );
    return $signed(data[lane*LANE_BITS + SAMPLE_LSB +: SAMPLE_BITS]);
  endfunction

endpackage

// File: rtl/adc_lane_crossing.sv
// Per-lane threshold compare, cross-word history and edge detection, then a
// lowest-lane priority encode. Two register stages from accepted word to hit.
module adc_lane_crossing
  import adc_trig_pkg::*;
(
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_BITS-1:0]     i_tdata,
  input  logic                     i_tvalid,
  input  logic [SAMPLE_BITS-1:0]   i_threshold,
  input  logic [1:0]               i_mode,
  input  logic                     i_hist_clr,
  output logic                     o_hit,
  output logic [LANE_IDX_BITS-1:0] o_lane,
  output logic                     o_valid
);

  logic [NLANES-1:0]        w_above;
  logic [NLANES-1:0]        w_prev_vec;
  logic [NLANES-1:0]        w_rise;
  logic [NLANES-1:0]        w_fall;
  logic [NLANES-1:0]        w_sel;
  logic [LANE_IDX_BITS-1:0] w_lane;

  logic [NLANES-1:0]        r_s1_above;
  logic                     r_s1_prev;
  logic                     r_s1_hv;
  logic [1:0]               r_s1_mode;
  logic                     r_s1_valid;
  logic                     r_last7;
  logic                     r_hist;

  logic                     r_hit;
  logic [LANE_IDX_BITS-1:0] r_lane;
  logic                     r_valid;

  always_comb begin
    w_above = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      w_above[i] = lane_sample(i_tdata, i) > $signed(i_threshold);
    end
  end

  // Stage 1: flags plus the last-lane flag of the previous accepted word; mode travels with the word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_s1_above <= '0;
      r_s1_prev  <= 1'b0;
      r_s1_hv    <= 1'b0;
      r_s1_mode  <= 2'd0;
      r_s1_valid <= 1'b0;
      r_last7    <= 1'b0;
      r_hist     <= 1'b0;
    end else begin
      r_s1_valid <= i_tvalid;
      if (i_tvalid) begin
        r_s1_above <= w_above;
        r_s1_prev  <= r_last7;
        r_s1_hv    <= r_hist;
        r_s1_mode  <= i_mode;
        r_last7    <= w_above[NLANES-1];
      end
      if (i_hist_clr) begin
        r_hist <= 1'b0;
      end else if (i_tvalid) begin
        r_hist <= 1'b1;
      end
    end
  end

  always_comb begin
    w_prev_vec = {r_s1_above[NLANES-2:0], r_s1_prev};
    w_rise     = r_s1_above & ~w_prev_vec;
    w_fall     = ~r_s1_above & w_prev_vec;
    w_rise[0]  = w_rise[0] & r_s1_hv;
    w_fall[0]  = w_fall[0] & r_s1_hv;
    case (r_s1_mode)
      MODE_FALL: w_sel = w_fall;
      MODE_BOTH: w_sel = w_rise | w_fall;
      default:   w_sel = w_rise;
    endcase
    w_lane = '0;
    for (int i = int'(NLANES) - 1; i >= 0; i--) begin
      if (w_sel[i]) begin
        w_lane = LANE_IDX_BITS'(i);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_hit   <= 1'b0;
      r_lane  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_hit   <= r_s1_valid & (|w_sel);
      r_lane  <= w_lane;
      r_valid <= r_s1_valid;
    end
  end

  assign o_hit   = r_hit;
  assign o_lane  = r_lane;
  assign o_valid = r_valid;

endmodule

// File: rtl/adc_level_trigger.sv
// Threshold-crossing trigger for the RFDC ADC stream, driving the ILA
// trigger_in/trigger_ack handshake with force, holdoff and auto re-arm.
module adc_level_trigger
  import adc_trig_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned COUNT_BITS     = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [DATA_BITS-1:0]     adc_tdata,
  input  logic                     adc_tvalid,
  input  logic [SAMPLE_BITS-1:0]   threshold,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     auto_rearm,
  input  logic                     force_trig,
  output logic                     trigger_out,
  input  logic                     trigger_ack,
  output logic [LANE_IDX_BITS-1:0] trig_lane,
  output logic                     trig_forced,
  output logic                     armed,
  output logic [COUNT_BITS-1:0]    trig_count
);

  localparam int unsigned HOLD_BITS = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLDOFF_CYCLES - 1);

  logic                     w_s2_hit;
  logic [LANE_IDX_BITS-1:0] w_s2_lane;
  logic                     w_s2_valid;
  logic                     w_hist_clr;

  logic                     r_s3_hit;
  logic [LANE_IDX_BITS-1:0] r_s3_lane;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [HOLD_BITS-1:0]     r_hold;
  logic [HOLD_BITS-1:0]     w_hold_nxt;
  logic [LANE_IDX_BITS-1:0] r_trig_lane;
  logic [LANE_IDX_BITS-1:0] w_lane_nxt;
  logic                     r_trig_forced;
  logic                     w_forced_nxt;
  logic [COUNT_BITS-1:0]    r_trig_count;
  logic [COUNT_BITS-1:0]    w_count_nxt;
  logic                     r_trigger_out;
  logic                     r_armed;

  adc_lane_crossing u_crossing (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_tdata     (adc_tdata),
    .i_tvalid    (adc_tvalid),
    .i_threshold (threshold),
    .i_mode      (mode),
    .i_hist_clr  (w_hist_clr),
    .o_hit       (w_s2_hit),
    .o_lane      (w_s2_lane),
    .o_valid     (w_s2_valid)
  );

  // Stage 3: align the hit with the FSM so a word fires three edges after acceptance.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_s3_hit  <= 1'b0;
      r_s3_lane <= '0;
    end else begin
      r_s3_hit  <= w_s2_valid & w_s2_hit;
      r_s3_lane <= w_s2_lane;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_lane_nxt   = r_trig_lane;
    w_forced_nxt = r_trig_forced;
    w_count_nxt  = r_trig_count;
    w_hist_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state_nxt = ST_ARMED;
          w_hist_clr  = 1'b1;
        end
      end
      ST_ARMED: begin
        // A data hit outranks a simultaneous force.
        if (r_s3_hit) begin
          w_state_nxt  = ST_FIRE;
          w_lane_nxt   = r_s3_lane;
          w_forced_nxt = 1'b0;
          w_count_nxt  = r_trig_count + COUNT_BITS'(1);
        end else if (force_trig) begin
          w_state_nxt  = ST_FIRE;
          w_lane_nxt   = '0;
          w_forced_nxt = 1'b1;
          w_count_nxt  = r_trig_count + COUNT_BITS'(1);
        end
      end
      ST_FIRE: begin
        if (trigger_ack) begin
          w_state_nxt = ST_HOLDOFF;
          w_hold_nxt  = HOLD_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (r_hold == '0) begin
          w_state_nxt = auto_rearm ? ST_ARMED : ST_IDLE;
        end else begin
          w_hold_nxt = r_hold - HOLD_BITS'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_hold        <= '0;
      r_trig_lane   <= '0;
      r_trig_forced <= 1'b0;
      r_trig_count  <= '0;
      r_trigger_out <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_trig_lane   <= w_lane_nxt;
      r_trig_forced <= w_forced_nxt;
      r_trig_count  <= w_count_nxt;
      r_trigger_out <= (w_state_nxt == ST_FIRE);
      r_armed       <= (w_state_nxt == ST_ARMED);
    end
  end

  assign trigger_out = r_trigger_out;
  assign trig_lane   = r_trig_lane;
  assign trig_forced = r_trig_forced;
  assign armed       = r_armed;
  assign trig_count  = r_trig_count;

endmodule

// File: tb/tb_adc_level_trigger.sv
// Directed bench for adc_level_trigger: latency, history masking, modes,
// handshake, holdoff, force, reset and counter wrap.
module tb_adc_level_trigger;

  localparam int unsigned HOLD = 16;
  localparam int unsigned CB   = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [127:0]  adc_tdata = '0;
  logic          adc_tvalid = 1'b0;
  logic [11:0]   threshold = 12'd100;
  logic [1:0]    mode = 2'd0;
  logic          arm = 1'b0;
  logic          auto_rearm = 1'b1;
  logic          force_trig = 1'b0;
  logic          trigger_ack = 1'b0;
  logic          trigger_out;
  logic [2:0]    trig_lane;
  logic          trig_forced;
  logic          armed;
  logic [CB-1:0] trig_count;

  int errors = 0;
  int checks = 0;

  adc_level_trigger #(.HOLDOFF_CYCLES(HOLD), .COUNT_BITS(CB)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .adc_tdata   (adc_tdata),
    .adc_tvalid  (adc_tvalid),
    .threshold   (threshold),
    .mode        (mode),
    .arm         (arm),
    .auto_rearm  (auto_rearm),
    .force_trig  (force_trig),
    .trigger_out (trigger_out),
    .trigger_ack (trigger_ack),
    .trig_lane   (trig_lane),
    .trig_forced (trig_forced),
    .armed       (armed),
    .trig_count  (trig_count)
  );

  always #5 aclk = ~aclk;

  function automatic logic [127:0] all_lanes(input int v);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = {12'(v), 4'h0};
    return w;
  endfunction

  function automatic logic [127:0] set_lane(input logic [127:0] w, input int i, input int v);
    logic [127:0] r;
    r = w;
    r[i*16 +: 16] = {12'(v), 4'h0};
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [127:0] w);
    adc_tdata  = w;
    adc_tvalid = 1'b1;
    tick();
    adc_tvalid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Acknowledge then sit out the full holdoff window.
  task automatic ack_holdoff();
    trigger_ack = 1'b1;
    tick();
    trigger_ack = 1'b0;
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_trig: got %0b want 0", trigger_out); end
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %0b want 0", armed); end
    checks++;
    if (trig_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", trig_count); end
    checks++;
    if (trig_lane !== 3'd0 || trig_forced !== 1'b0) begin
      errors++; $display("FAIL reset_lane_forced: lane=%0d forced=%0b want 0/0", trig_lane, trig_forced);
    end
    checks++;
  endtask

  task automatic test_first_word();
    logic [127:0] w;
    mode = 2'd0;
    threshold = 12'd100;
    send(all_lanes(-300));
    pulse_arm();
    if (armed !== 1'b1) begin errors++; $display("FAIL arm: armed=%0b want 1", armed); end
    checks++;
    w = all_lanes(300);
    w = set_lane(w, 1, -300);
    w = set_lane(w, 2, -300);
    send(w);
    tick();
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL first_early: trig=%0b want 0", trigger_out); end
    checks++;
    tick();
    if (trigger_out !== 1'b1 || trig_lane !== 3'd3) begin
      errors++; $display("FAIL first_word_mask: trig=%0b lane=%0d want 1/3", trigger_out, trig_lane);
    end
    checks++;
    if (trig_count !== 4'd1) begin errors++; $display("FAIL first_count: got %0d want 1", trig_count); end
    checks++;
  endtask

  task automatic test_hold_ack();
    logic dropped;
    dropped = 1'b0;
    auto_rearm = 1'b1;
    for (int i = 0; i < 50; i++) begin
      adc_tdata  = (i % 2 == 0) ? all_lanes(300) : all_lanes(-200);
      adc_tvalid = 1'b1;
      tick();
      if (trigger_out !== 1'b1) dropped = 1'b1;
    end
    adc_tvalid = 1'b0;
    if (dropped !== 1'b0) begin errors++; $display("FAIL hold_level: trigger_out dropped=%0b want 0", dropped); end
    checks++;
    if (trig_count !== 4'd1 || trig_lane !== 3'd3) begin
      errors++; $display("FAIL hold_ignore: count=%0d lane=%0d want 1/3", trig_count, trig_lane);
    end
    checks++;
    trigger_ack = 1'b1;
    tick();
    trigger_ack = 1'b0;
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL ack_drop: trig=%0b want 0", trigger_out); end
    checks++;
    dropped = 1'b0;
    repeat (HOLD - 1) begin
      tick();
      if (armed !== 1'b0) dropped = 1'b1;
    end
    if (dropped !== 1'b0) begin errors++; $display("FAIL holdoff_early: armed seen=%0b want 0", dropped); end
    checks++;
    tick();
    if (armed !== 1'b1) begin errors++; $display("FAIL holdoff_rearm: armed=%0b want 1", armed); end
    checks++;
  endtask

  task automatic test_rise();
    logic [127:0] w;
    send(all_lanes(-200));
    w = all_lanes(300);
    for (int i = 0; i < 5; i++) w = set_lane(w, i, -200);
    send(w);
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL rise_k1: trig=%0b want 0", trigger_out); end
    checks++;
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL rise_k2: trig=%0b want 0", trigger_out); end
    checks++;
    tick();
    if (trigger_out !== 1'b1 || trig_lane !== 3'd5 || trig_forced !== 1'b0) begin
      errors++; $display("FAIL rise_k3: trig=%0b lane=%0d forced=%0b want 1/5/0", trigger_out, trig_lane, trig_forced);
    end
    checks++;
    if (trig_count !== 4'd2 || armed !== 1'b0) begin
      errors++; $display("FAIL rise_count: count=%0d armed=%0b want 2/0", trig_count, armed);
    end
    checks++;
    ack_holdoff();
    if (armed !== 1'b1) begin errors++; $display("FAIL rise_rearm: armed=%0b want 1", armed); end
    checks++;
  endtask

  task automatic test_cross_word();
    logic seen;
    mode = 2'd1;
    send(all_lanes(300));
    send(all_lanes(300));
    send(all_lanes(-300));
    tick();
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL xword_early: trig=%0b want 0", trigger_out); end
    checks++;
    tick();
    if (trigger_out !== 1'b1 || trig_lane !== 3'd0 || trig_count !== 4'd3) begin
      errors++; $display("FAIL xword_fall: trig=%0b lane=%0d count=%0d want 1/0/3", trigger_out, trig_lane, trig_count);
    end
    checks++;
    ack_holdoff();
    send(all_lanes(300));
    mode = 2'd0;
    send(all_lanes(300));
    send(all_lanes(-300));
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (trigger_out !== 1'b0) seen = 1'b1;
    end
    if (seen !== 1'b0 || armed !== 1'b1) begin
      errors++; $display("FAIL xword_rise_none: fired=%0b armed=%0b want 0/1", seen, armed);
    end
    checks++;
  endtask

  task automatic test_force();
    logic [127:0] w;
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    if (trigger_out !== 1'b1 || trig_forced !== 1'b1 || trig_lane !== 3'd0) begin
      errors++; $display("FAIL force_armed: trig=%0b forced=%0b lane=%0d want 1/1/0", trigger_out, trig_forced, trig_lane);
    end
    checks++;
    if (trig_count !== 4'd4) begin errors++; $display("FAIL force_count: got %0d want 4", trig_count); end
    checks++;
    auto_rearm = 1'b0;
    ack_holdoff();
    if (armed !== 1'b0 || trigger_out !== 1'b0) begin
      errors++; $display("FAIL no_rearm: armed=%0b trig=%0b want 0/0", armed, trigger_out);
    end
    checks++;
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    repeat (3) tick();
    if (trigger_out !== 1'b0 || trig_count !== 4'd4) begin
      errors++; $display("FAIL force_idle: trig=%0b count=%0d want 0/4", trigger_out, trig_count);
    end
    checks++;
    pulse_arm();
    send(all_lanes(-200));
    w = all_lanes(300);
    w = set_lane(w, 0, -200);
    w = set_lane(w, 1, -200);
    send(w);
    tick();
    tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    if (trigger_out !== 1'b1 || trig_lane !== 3'd2 || trig_forced !== 1'b0 || trig_count !== 4'd5) begin
      errors++; $display("FAIL hit_beats_force: trig=%0b lane=%0d forced=%0b count=%0d want 1/2/0/5",
                         trigger_out, trig_lane, trig_forced, trig_count);
    end
    checks++;
  endtask

  task automatic test_reset_fire();
    aresetn = 1'b0;
    tick();
    if (trigger_out !== 1'b0 || trig_count !== 4'd0 || armed !== 1'b0) begin
      errors++; $display("FAIL reset_fire: trig=%0b count=%0d armed=%0b want 0/0/0", trigger_out, trig_count, armed);
    end
    checks++;
    aresetn = 1'b1;
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL reset_fire_hold: trig=%0b want 0", trigger_out); end
    checks++;
  endtask

  task automatic test_gaps();
    logic [127:0] w;
    logic seen;
    auto_rearm = 1'b1;
    mode = 2'd0;
    pulse_arm();
    send(all_lanes(-200));
    repeat (3) tick();
    w = all_lanes(300);
    for (int i = 0; i < 6; i++) w = set_lane(w, i, -200);
    send(w);
    tick();
    tick();
    if (trigger_out !== 1'b0) begin errors++; $display("FAIL gap_early: trig=%0b want 0", trigger_out); end
    checks++;
    tick();
    if (trigger_out !== 1'b1 || trig_lane !== 3'd6 || trig_count !== 4'd1) begin
      errors++; $display("FAIL gap_latency: trig=%0b lane=%0d count=%0d want 1/6/1", trigger_out, trig_lane, trig_count);
    end
    checks++;
    ack_holdoff();
    seen = 1'b0;
    for (int n = 0; n < 2; n++) begin
      send(all_lanes(-200));
      repeat (3) begin
        tick();
        if (trigger_out !== 1'b0) seen = 1'b1;
      end
    end
    if (seen !== 1'b0 || trig_count !== 4'd1 || armed !== 1'b1) begin
      errors++; $display("FAIL gap_false: fired=%0b count=%0d armed=%0b want 0/1/1", seen, trig_count, armed);
    end
    checks++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      ack_holdoff();
      if (i == 13) begin
        if (trig_count !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d want 15", trig_count); end
        checks++;
      end
    end
    if (trig_count !== 4'd0 || armed !== 1'b1) begin
      errors++; $display("FAIL wrap_zero: count=%0d armed=%0b want 0/1", trig_count, armed);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_hold_ack();
    test_rise();
    test_cross_word();
    test_force();
    test_reset_fire();
    test_gaps();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_level_trigger.md
Name: adc_level_trigger

Overview:
Level/edge trigger generator that watches the 128-bit RFDC ADC AXI4-Stream (8 lanes × 16 bit, 12-bit sample left-justified) and raises an ILA-style trigger when the signal crosses a programmable threshold. It sits directly upstream of adc_ila_transfer and drives its trigger_in/trigger_ack handshake in place of the ILA's own trig_out. Supports rising, falling or either-edge detection, software force, holdoff and auto re-arm.

Parameters:
HOLDOFF_CYCLES, 256, aclk cycles spent in HOLDOFF after each acknowledged trigger (≥1)
COUNT_BITS, 16, width of trig_count

Ports:
aclk  in  1  stream clock, single clock domain
aresetn  in  1  synchronous active-low reset
adc_tdata  in  128  8 samples; lane i = bits [16i+15:16i+4], signed 12-bit; lane 0 earliest in time
adc_tvalid  in  1  word valid; no tready, block never stalls the stream
threshold  in  12  signed threshold, sampled per accepted word
mode  in  2  0 rising, 1 falling, 2 either, 3 reserved (treated as rising)
arm  in  1  one-cycle pulse: IDLE→ARMED
auto_rearm  in  1  1 = HOLDOFF returns to ARMED, 0 = returns to IDLE
force_trig  in  1  one-cycle pulse: fire immediately if ARMED
trigger_out  out  1  level, held until trigger_ack
trigger_ack  in  1  acknowledge from consumer
trig_lane  out  3  lane of first crossing in firing word
trig_forced  out  1  1 if current/last trigger came from force_trig
armed  out  1  high in ARMED
trig_count  out  COUNT_BITS  triggers fired since reset, wraps

Behaviour:
- Reset (aresetn=0 at aclk edge): state IDLE; trigger_out=0, trig_lane=0, trig_forced=0, armed=0, trig_count=0; history invalid; pipeline valids cleared.
- Stage 1 (word accepted with adc_tvalid=1 at edge k): register above[i] = (sample_i > threshold) for 8 lanes, plus above_prev = lane-7 flag of previous accepted word, and hist_valid.
- Stage 2 (k+1): rise[i] = above[i] & ~above[i-1]; fall[i] = ~above[i] & above[i-1]; lane 0 uses above_prev, masked when hist_valid=0. Select per mode; priority-encode lowest lane; register hit and lane.
- Stage 3 (k+2): FSM consumes hit; trigger_out rises at edge k+3 (3-cycle latency word→trigger).
- adc_tvalid=0: pipeline holds, no hit generated; history retained across gaps.
- hist_valid cleared on reset and on each IDLE→ARMED transition; set after first accepted word.
- FSM states: IDLE, ARMED, FIRE, HOLDOFF.
  IDLE: arm→ARMED. Hits and force ignored.
  ARMED: data hit or force_trig→FIRE; latch trig_lane (0 if forced), trig_forced, trig_count+1. Simultaneous hit and force: data hit wins, trig_forced=0.
  FIRE: trigger_out=1; trigger_ack→HOLDOFF, trigger_out=0 next cycle. Hits ignored.
  HOLDOFF: counter loads HOLDOFF_CYCLES-1, decrements; at 0 → ARMED if auto_rearm else IDLE. auto_rearm sampled on exit cycle.
- arm in ARMED/FIRE/HOLDOFF ignored. trigger_ack outside FIRE ignored. trigger_ack coincident with FIRE entry not honoured until the cycle after FIRE entry.
- Hit arriving on the cycle of IDLE→ARMED is ignored (armed effective next cycle).
- threshold/mode changes take effect for the next accepted word; in-flight pipeline words use old values.
- trig_count wraps 2^COUNT_BITS-1→0.
- Reset mid-FIRE: trigger_out low on the next edge, no ack required.

Decomposition:
- Package adc_trig_pkg: NLANES=8, LANE_BITS=16, SAMPLE_BITS=12, SAMPLE_LSB=4; mode enum (MODE_RISE, MODE_FALL, MODE_BOTH); state enum (ST_IDLE, ST_ARMED, ST_FIRE, ST_HOLDOFF); lane-extract function.
- Sub-module adc_lane_crossing: stages 1–2 (compare, history, edge detect, priority encode) outputting hit/lane/valid; FSM, counters and handshake stay in top.

Test Plan:
- Reset, arm, mode=0, threshold=100; words all -200 then word with lane 5 = 300 (lanes 0–4 -200) → trigger_out rises 3 cycles after that word, trig_lane=5, trig_count=1.
- Cross-word edge: lane 7 = 300 in word N, lane 0 = -300 in word N+1, mode=1 → trig_lane=0 on word N+1; same sequence with mode=0 → no trigger.
- First word after arm has lane 0 = 300, previous pre-arm word lane 7 = -300 → no trigger (history invalid); lane 3 crossing in same word → trig_lane=3.
- Hold trigger_ack=0 for 50 cycles → trigger_out stays 1, further crossings ignored; ack → trigger_out 0 next cycle; HOLDOFF_CYCLES=16, auto_rearm=1 → armed=1 exactly 16 cycles later.
- force_trig while ARMED with no crossing → trigger_out=1, trig_forced=1, trig_lane=0; force_trig in IDLE → no effect.
- aresetn=0 while trigger_out=1 → trigger_out=0, state IDLE, trig_count=0 on next edge; adc_tvalid gaps of 3 cycles between crossing words → hit latency counted from accepting edge, no false triggers.
